// File: rtl/decode_cycle.sv
// Decode stage: instruction field decode, register file (r0 hard-wired to zero), D/E pipeline register.
// Optional DECODE_BYPASS_EN: same-cycle writeback data is forwarded to the rs1/rs2 reads.
module decode_cycle #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [33:0]       InstrD,
   input  logic [8:0]        PCD,
   input  logic [8:0]        PCPlus4D,
   input  logic              PCSrcE,
   input  logic              FlushE,
   input  logic              RegWriteW,
   input  logic [3:0]        RdW,
   input  logic [DATA_W-1:0] ResultW,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] ImmExtE,
   output logic [3:0]        RdE,
   output logic [3:0]        Rs1E,
   output logic [3:0]        Rs2E,
   output logic [8:0]        PCE,
   output logic [8:0]        PCPlus4E,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              MemReadE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [2:0]        ALUOpE
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   logic [DATA_W-1:0] r_regs [NREGS];

   logic [4:0]        w_op;
   logic [3:0]        w_rd;
   logic [3:0]        w_rs1;
   logic [3:0]        w_rs2;
   logic [16:0]       w_imm;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_reg_write;
   logic              w_mem_write;
   logic              w_mem_read;
   logic              w_branch;
   logic              w_alu_src;
   logic [2:0]        w_alu_op;
   logic              w_flush;
   logic              w_wb_en;

   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic [DATA_W-1:0] r_imm_ext;
   logic [3:0]        r_rd;
   logic [3:0]        r_rs1;
   logic [3:0]        r_rs2;
   logic [8:0]        r_pc;
   logic [8:0]        r_pc_plus4;
   logic              r_reg_write;
   logic              r_mem_write;
   logic              r_mem_read;
   logic              r_branch;
   logic              r_alu_src;
   logic [2:0]        r_alu_op;

   assign w_op      = InstrD[33:29];
   assign w_rd      = InstrD[28:25];
   assign w_rs1     = InstrD[24:21];
   assign w_rs2     = InstrD[20:17];
   assign w_imm     = InstrD[16:0];
   assign w_imm_ext = DATA_W'($signed(w_imm));
   assign w_flush   = PCSrcE | FlushE;
   assign w_wb_en   = RegWriteW && (RdW != 4'd0) && (int'(RdW) < NREGS);

   always_comb begin
      w_reg_write = 1'b0;
      w_mem_write = 1'b0;
      w_mem_read  = 1'b0;
      w_branch    = 1'b0;
      w_alu_src   = 1'b0;
      w_alu_op    = ALU_ADD;
      unique case (w_op[4:3])
         2'b00: begin
            w_reg_write = 1'b1;
            w_alu_op    = w_op[2:0];
         end
         2'b01: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_alu_op    = w_op[2:0];
         end
         2'b10: begin
            w_alu_src = 1'b1;
            if (w_op[0]) begin
               w_mem_write = 1'b1;
            end else begin
               w_mem_read  = 1'b1;
               w_reg_write = 1'b1;
            end
         end
         default: begin
            w_branch = 1'b1;
            w_alu_op = ALU_SUB;
         end
      endcase
      // a write to r0 would be discarded anyway; suppress it so execute sees no side effect
      if (w_rd == 4'd0) w_reg_write = 1'b0;
   end

   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      if (w_rs1 != 4'd0 && int'(w_rs1) < NREGS) w_rd1 = r_regs[w_rs1];
      if (w_rs2 != 4'd0 && int'(w_rs2) < NREGS) w_rd2 = r_regs[w_rs2];
`ifdef DECODE_BYPASS_EN
      if (w_wb_en && RdW == w_rs1) w_rd1 = ResultW;
      if (w_wb_en && RdW == w_rs2) w_rd2 = ResultW;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wb_en) begin
         r_regs[RdW] <= ResultW;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || w_flush) begin
         r_rd1       <= '0;
         r_rd2       <= '0;
         r_imm_ext   <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_pc        <= '0;
         r_pc_plus4  <= '0;
         r_reg_write <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_branch    <= 1'b0;
         r_alu_src   <= 1'b0;
         r_alu_op    <= '0;
      end else begin
         r_rd1       <= w_rd1;
         r_rd2       <= w_rd2;
         r_imm_ext   <= w_imm_ext;
         r_rd        <= w_rd;
         r_rs1       <= w_rs1;
         r_rs2       <= w_rs2;
         r_pc        <= PCD;
         r_pc_plus4  <= PCPlus4D;
         r_reg_write <= w_reg_write;
         r_mem_write <= w_mem_write;
         r_mem_read  <= w_mem_read;
         r_branch    <= w_branch;
         r_alu_src   <= w_alu_src;
         r_alu_op    <= w_alu_op;
      end
   end

   assign RD1E      = r_rd1;
   assign RD2E      = r_rd2;
   assign ImmExtE   = r_imm_ext;
   assign RdE       = r_rd;
   assign Rs1E      = r_rs1;
   assign Rs2E      = r_rs2;
   assign PCE       = r_pc;
   assign PCPlus4E  = r_pc_plus4;
   assign RegWriteE = r_reg_write;
   assign MemWriteE = r_mem_write;
   assign MemReadE  = r_mem_read;
   assign BranchE   = r_branch;
   assign ALUSrcE   = r_alu_src;
   assign ALUOpE    = r_alu_op;

endmodule

// File: tb/tb_decode_cycle.sv
// Randomized bench for decode_cycle against a behavioural decode/register-file model.
// Build with DECODE_BYPASS_EN to match an RTL built with the same-cycle bypass.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [33:0] InstrD = '0;
   logic [8:0]  PCD = '0, PCPlus4D = '0;
   logic        PCSrcE = 1'b0, FlushE = 1'b0, RegWriteW = 1'b0;
   logic [3:0]  RdW = '0;
   logic [31:0] ResultW = '0;
   logic [31:0] RD1E, RD2E, ImmExtE;
   logic [3:0]  RdE, Rs1E, Rs2E;
   logic [8:0]  PCE, PCPlus4E;
   logic        RegWriteE, MemWriteE, MemReadE, BranchE, ALUSrcE;
   logic [2:0]  ALUOpE;

   decode_cycle #(.DATA_W(32), .NREGS(16)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .PCSrcE(PCSrcE), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .MemReadE(MemReadE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd1, rd2, imm;
      logic [3:0]  rd, rs1, rs2;
      logic [8:0]  pc, pc4;
      logic        rw, mw, mr, br, as;
      logic [2:0]  aop;
   } exp_t;

   logic [31:0] m_regs [16];
   int n_tests = 0;
   int n_fail  = 0;

`ifdef DECODE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [33:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [16:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic logic [31:0] read_reg(input int idx);
      if (idx == 0) return 32'd0;
      if (BYPASS && RegWriteW && int'(RdW) == idx) return ResultW;
      return m_regs[idx];
   endfunction

   // Expected D/E contents for the instruction currently presented, from the opcode-class rules.
   function automatic exp_t model();
      exp_t e;
      int   cls;
      logic [4:0] op;
      e = '0;
      if (PCSrcE || FlushE) return e;
      op    = InstrD[33:29];
      cls   = int'(op[4:3]);
      e.rd  = InstrD[28:25];
      e.rs1 = InstrD[24:21];
      e.rs2 = InstrD[20:17];
      e.imm = InstrD[16] ? (32'hFFFE_0000 | 32'(InstrD[16:0])) : 32'(InstrD[16:0]);
      e.pc  = PCD;
      e.pc4 = PCPlus4D;
      e.rd1 = read_reg(int'(e.rs1));
      e.rd2 = read_reg(int'(e.rs2));
      if (cls == 0) begin e.rw = 1; e.aop = op[2:0]; end
      else if (cls == 1) begin e.rw = 1; e.as = 1; e.aop = op[2:0]; end
      else if (cls == 2) begin
         e.as = 1;
         if (op[0]) e.mw = 1; else begin e.mr = 1; e.rw = 1; end
      end else begin e.br = 1; e.aop = 3'd1; end
      if (e.rd == 0) e.rw = 0;
      return e;
   endfunction

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".RD1E"},      64'(RD1E),      64'(e.rd1));
      check({tag, ".RD2E"},      64'(RD2E),      64'(e.rd2));
      check({tag, ".ImmExtE"},   64'(ImmExtE),   64'(e.imm));
      check({tag, ".RdE"},       64'(RdE),       64'(e.rd));
      check({tag, ".Rs1E"},      64'(Rs1E),      64'(e.rs1));
      check({tag, ".Rs2E"},      64'(Rs2E),      64'(e.rs2));
      check({tag, ".PCE"},       64'(PCE),       64'(e.pc));
      check({tag, ".PCPlus4E"},  64'(PCPlus4E),  64'(e.pc4));
      check({tag, ".RegWriteE"}, 64'(RegWriteE), 64'(e.rw));
      check({tag, ".MemWriteE"}, 64'(MemWriteE), 64'(e.mw));
      check({tag, ".MemReadE"},  64'(MemReadE),  64'(e.mr));
      check({tag, ".BranchE"},   64'(BranchE),   64'(e.br));
      check({tag, ".ALUSrcE"},   64'(ALUSrcE),   64'(e.as));
      check({tag, ".ALUOpE"},    64'(ALUOpE),    64'(e.aop));
   endtask

   // One clock: predict from current inputs, commit the model write, compare #1 after the edge.
   task automatic cycle(input string tag);
      exp_t e;
      e = model();
      @(posedge clk);
      #1;
      if (RegWriteW && RdW != 0) m_regs[RdW] = ResultW;
      check_all(tag, e);
   endtask

   task automatic idle_inputs();
      InstrD = '0; PCSrcE = 0; FlushE = 0; RegWriteW = 0; RdW = '0; ResultW = '0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;

      // Reset held with garbage on the inputs
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         InstrD = {2'($urandom_range(3, 0)), 32'($urandom)};
         PCD = 9'($urandom); PCPlus4D = 9'($urandom);
         RegWriteW = 1; RdW = 4'($urandom_range(15, 1)); ResultW = $urandom;
         @(posedge clk); #1;
         check_all("reset_hold", '0);
      end
      idle_inputs();
      rst = 1;

      for (int r = 1; r < 16; r++) begin
         InstrD = mk(5'b00000, 4'd1, 4'(r), 4'(r), 17'd0);
         cycle("reset_read");
      end

      // Writeback then a dependent ALU-reg read
      InstrD = '0; RegWriteW = 1; RdW = 4'd3; ResultW = 32'h1234;
      cycle("wb_r3");
      RegWriteW = 0;
      InstrD = mk(5'b00000, 4'd5, 4'd3, 4'd0, 17'd0);
      cycle("alu_reg");
      check("alu_reg.RD1E_const", 64'(RD1E), 64'h1234);

      InstrD = mk(5'b01010, 4'd2, 4'd0, 4'd0, 17'h1FFFC);
      cycle("alu_imm");
      check("alu_imm.ImmExtE_const", 64'(ImmExtE), 64'hFFFF_FFFC);

      InstrD = mk(5'b10001, 4'd7, 4'd3, 4'd3, 17'd8);
      cycle("store");
      InstrD = mk(5'b10000, 4'd0, 4'd3, 4'd0, 17'd4);
      cycle("load_r0");
      check("load_r0.MemReadE_const", 64'(MemReadE), 64'd1);

      InstrD = mk(5'b11000, 4'd0, 4'd3, 4'd5, 17'h1FFF0);
      PCD = 9'h1FC; PCPlus4D = 9'h000;
      cycle("branch");
      check("branch.PCE_const", 64'(PCE), 64'h1FC);
      PCSrcE = 1;
      cycle("branch_flush");
      PCSrcE = 0; FlushE = 1; RegWriteW = 1; RdW = 4'd9; ResultW = 32'hBEEF;
      cycle("flush_with_wb");
      idle_inputs();
      InstrD = mk(5'b00001, 4'd6, 4'd9, 4'd0, 17'd0);
      cycle("flush_wb_commit");
      check("flush_wb_commit.RD1E_const", 64'(RD1E), 64'hBEEF);

      // Same-cycle writeback/read hazard
      RegWriteW = 1; RdW = 4'd4; ResultW = 32'h11; InstrD = '0;
      cycle("wb_r4_old");
      RegWriteW = 1; RdW = 4'd4; ResultW = 32'hAA;
      InstrD = mk(5'b00000, 4'd8, 4'd4, 4'd4, 17'd0);
      cycle("hazard");
      check("hazard.RD1E_const", 64'(RD1E), BYPASS ? 64'hAA : 64'h11);
      RegWriteW = 1; RdW = 4'd0; ResultW = 32'hDEAD;
      InstrD = mk(5'b00000, 4'd8, 4'd0, 4'd0, 17'd0);
      cycle("wb_r0");
      RegWriteW = 0;
      cycle("read_r0");
      check("read_r0.RD1E_const", 64'(RD1E), 64'd0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         InstrD    = {2'($urandom_range(3, 0)), 32'($urandom)};
         PCD       = 9'($urandom);
         PCPlus4D  = PCD + 9'd4;
         PCSrcE    = ($urandom_range(9, 0) == 0);
         FlushE    = ($urandom_range(9, 0) == 0);
         RegWriteW = ($urandom_range(1, 0) == 1);
         RdW       = 4'($urandom);
         ResultW   = $urandom;
         cycle("rand");
      end

      // Asynchronous reset mid-operation, between clock edges
      idle_inputs();
      InstrD = mk(5'b01000, 4'd3, 4'd9, 4'd3, 17'h00123);
      cycle("pre_async");
      #2 rst = 0;
      #1 check_all("async_rst", '0);
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      @(posedge clk); #1;
      rst = 1;
      for (int r = 1; r < 16; r++) begin
         InstrD = mk(5'b00000, 4'd1, 4'(r), 4'(16 - r), 17'd0);
         cycle("post_rst_read");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
